// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared I/O slave.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface io_bus_arbiter_if;
  logic        m0_io_req;
  logic        m1_io_req;
  logic        m0_wrt;
  logic        m1_wrt;
  logic [15:0] m0_address;
  logic [15:0] m1_address;
  logic [7:0]  m0_wdata;
  logic [7:0]  m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [7:0]  m0_rdata;
  logic [7:0]  m1_rdata;
  logic        m0_rdata_en;
  logic        m1_rdata_en;
  logic        bus_io_req;
  logic        bus_ack;
  logic        bus_wrt;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic        grant_id;

  modport master (
    input  m0_io_req, m1_io_req, m0_wrt, m1_wrt,
    input  m0_address, m1_address, m0_wdata, m1_wdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_rdata_en, m1_rdata_en,
    output bus_io_req, bus_wrt, bus_address, bus_wdata,
    input  bus_ack, bus_rdata, bus_rdata_en,
    output grant_id
  );

  modport slave (
    output m0_io_req, m1_io_req, m0_wrt, m1_wrt,
    output m0_address, m1_address, m0_wdata, m1_wdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_rdata_en, m1_rdata_en,
    input  bus_io_req, bus_wrt, bus_address, bus_wdata,
    output bus_ack, bus_rdata, bus_rdata_en,
    input  grant_id
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one I/O slave port between two masters, with a
// watchdog that force-completes transactions whose ack or read data never arrives.
module io_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            reset,
  io_bus_arbiter_if.master io
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wd_count;
  logic       last_grant;
  logic       rdata_pend;
  logic       pick_m1;
  logic       wd_expired;

  // m1 wins only when it is alone or m0 was served last.
  always_comb begin
    pick_m1    = io.m1_io_req && (!io.m0_io_req || !last_grant);
    wd_expired = (wd_count == WD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wd_count       <= 8'h00;
      last_grant     <= 1'b1;
      rdata_pend     <= 1'b0;
      io.m0_ack      <= 1'b0;
      io.m1_ack      <= 1'b0;
      io.m0_rdata    <= 8'h00;
      io.m1_rdata    <= 8'h00;
      io.m0_rdata_en <= 1'b0;
      io.m1_rdata_en <= 1'b0;
      io.bus_io_req  <= 1'b0;
      io.bus_wrt     <= 1'b0;
      io.bus_address <= 16'h0000;
      io.bus_wdata   <= 8'h00;
      io.grant_id    <= 1'b0;
    end else begin
      io.m0_ack      <= 1'b0;
      io.m1_ack      <= 1'b0;
      io.m0_rdata_en <= 1'b0;
      io.m1_rdata_en <= 1'b0;

      unique case (state)
        IDLE: begin
          if (io.m0_io_req || io.m1_io_req) begin
            io.bus_wrt     <= pick_m1 ? io.m1_wrt     : io.m0_wrt;
            io.bus_address <= pick_m1 ? io.m1_address : io.m0_address;
            io.bus_wdata   <= pick_m1 ? io.m1_wdata   : io.m0_wdata;
            io.grant_id    <= pick_m1;
            last_grant     <= pick_m1;
            io.bus_io_req  <= 1'b1;
            wd_count       <= 8'h00;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (io.bus_ack || wd_expired) begin
            io.bus_io_req <= 1'b0;
            io.m0_ack     <= !io.grant_id;
            io.m1_ack     <= io.grant_id;
            wd_count      <= 8'h00;
            if (io.bus_wrt) begin
              state <= DONE;
            end else if (io.bus_ack && !io.bus_rdata_en) begin
              state <= WAIT_DATA;
            end else begin
              // Data (real or FFh on timeout) is held now and announced from DONE.
              if (io.grant_id) io.m1_rdata <= io.bus_ack ? io.bus_rdata : 8'hFF;
              else             io.m0_rdata <= io.bus_ack ? io.bus_rdata : 8'hFF;
              rdata_pend <= 1'b1;
              state      <= DONE;
            end
          end else begin
            wd_count <= wd_count + 8'h01;
          end
        end

        WAIT_DATA: begin
          if (io.bus_rdata_en || wd_expired) begin
            if (io.grant_id) io.m1_rdata <= io.bus_rdata_en ? io.bus_rdata : 8'hFF;
            else             io.m0_rdata <= io.bus_rdata_en ? io.bus_rdata : 8'hFF;
            io.m0_rdata_en <= !io.grant_id;
            io.m1_rdata_en <= io.grant_id;
            wd_count       <= 8'h00;
            state          <= DONE;
          end else begin
            wd_count <= wd_count + 8'h01;
          end
        end

        DONE: begin
          io.m0_rdata_en <= rdata_pend && !io.grant_id;
          io.m1_rdata_en <= rdata_pend && io.grant_id;
          rdata_pend     <= 1'b0;
          wd_count       <= 8'h00;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized scoreboard bench for io_bus_arbiter: a transaction-level model predicts
// grant order, forwarded commands and each master's ack/read-data responses with latencies.
module tb_io_bus_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  typedef struct {
    bit         is_data;
    logic [7:0] data;
    int         latency;
  } resp_t;

  typedef struct {
    bit          wrt;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          id;
  } cmd_t;

  typedef struct {
    int ack_delay;
    int data_delay;
  } slv_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;

  io_bus_arbiter_if io ();

  io_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  resp_t      m0_q[$];
  resp_t      m1_q[$];
  cmd_t       bus_q[$];
  slv_t       slave_q[$];
  logic [7:0] model_mem [int];
  logic [7:0] slave_mem [int];
  bit         model_last = 1'b1;
  int         n_pass  = 0;
  int         n_total = 0;
  int         issue_cyc = 0;
  int         ack_cyc[2];
  logic       prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic pop_exp(input bit id, output bit ok, output resp_t r);
    ok = 1'b0;
    r  = '{1'b0, 8'h00, 0};
    if (id) begin
      if (m1_q.size() > 0) begin r = m1_q.pop_front(); ok = 1'b1; end
    end else begin
      if (m0_q.size() > 0) begin r = m0_q.pop_front(); ok = 1'b1; end
    end
  endtask

  task automatic observe(input bit id, input logic ack, input logic en, input logic [7:0] rdata);
    bit    ok;
    resp_t r;
    if (ack === 1'b1) begin
      pop_exp(id, ok, r);
      if (!ok) check($sformatf("m%0d_stray_ack", id), 1, 0);
      else begin
        check($sformatf("m%0d_ack_kind", id), r.is_data, 0);
        check($sformatf("m%0d_ack_latency", id), cycle - issue_cyc, r.latency);
        check("bus_req_drop_at_ack", io.bus_io_req, 0);
        ack_cyc[id] = cycle;
      end
    end
    if (en === 1'b1) begin
      pop_exp(id, ok, r);
      if (!ok) check($sformatf("m%0d_stray_rdata_en", id), 1, 0);
      else begin
        check($sformatf("m%0d_rdata_kind", id), r.is_data, 1);
        check($sformatf("m%0d_rdata", id), rdata, r.data);
        check($sformatf("m%0d_rdata_latency", id), cycle - ack_cyc[id], r.latency);
      end
    end
  endtask

  // Monitor: compares forwarded commands and master responses against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (io.bus_io_req === 1'b1 && !prev_req) begin
        issue_cyc = cycle;
        if (bus_q.size() == 0) check("bus_stray_issue", 1, 0);
        else begin
          cmd_t c;
          c = bus_q.pop_front();
          check("grant_id", io.grant_id, c.id);
          check("bus_wrt", io.bus_wrt, c.wrt);
          check("bus_address", io.bus_address, c.addr);
          check("bus_wdata", io.bus_wdata, c.wdata);
        end
      end
      prev_req = (io.bus_io_req === 1'b1);
      if ((io.m0_ack | io.m0_rdata_en | io.m1_ack | io.m1_rdata_en) === 1'b1)
        check("masters_exclusive", (io.m0_ack | io.m0_rdata_en) & (io.m1_ack | io.m1_rdata_en), 0);
      observe(1'b0, io.m0_ack, io.m0_rdata_en, io.m0_rdata);
      observe(1'b1, io.m1_ack, io.m1_rdata_en, io.m1_rdata);
    end
  end

  // Slave stub: memory-backed, with per-transaction ack/data delays (NEVER = stay silent).
  initial begin
    io.bus_ack      = 1'b0;
    io.bus_rdata_en = 1'b0;
    io.bus_rdata    = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && io.bus_io_req === 1'b1) begin
        slv_t        b;
        logic [15:0] a;
        logic [7:0]  v;
        b = (slave_q.size() > 0) ? slave_q.pop_front() : '{0, 0};
        a = io.bus_address;
        if (b.ack_delay == NEVER) begin
          for (int n = 0; n < 100 && io.bus_io_req === 1'b1; n++) @(negedge clk);
        end else begin
          repeat (b.ack_delay) @(negedge clk);
          v = slave_mem.exists(int'(a)) ? slave_mem[int'(a)] : 8'h00;
          if (io.bus_wrt) slave_mem[int'(a)] = io.bus_wdata;
          io.bus_ack = 1'b1;
          if (!io.bus_wrt && b.data_delay == 0) begin
            io.bus_rdata_en = 1'b1;
            io.bus_rdata    = v;
          end
          @(negedge clk);
          io.bus_ack      = 1'b0;
          io.bus_rdata_en = 1'b0;
          if (!io.bus_wrt && b.data_delay != 0 && b.data_delay != NEVER) begin
            repeat (b.data_delay - 1) @(negedge clk);
            io.bus_rdata_en = 1'b1;
            io.bus_rdata    = v;
            @(negedge clk);
            io.bus_rdata_en = 1'b0;
          end
        end
      end
    end
  end

  // Reference model: one serialized transaction, outcome derived from slave behaviour.
  task automatic model_txn(input bit id, input bit wrt, input logic [15:0] addr,
                           input logic [7:0] wdata, input int ak, input int dt);
    resp_t      rs[$];
    logic [7:0] v;
    bus_q.push_back('{wrt, addr, wdata, id});
    slave_q.push_back('{ak, dt});
    if (ak == NEVER) begin
      rs.push_back('{1'b0, 8'h00, TIMEOUT});
      if (!wrt) rs.push_back('{1'b1, 8'hFF, 1});
    end else begin
      rs.push_back('{1'b0, 8'h00, ak + 1});
      if (wrt) model_mem[int'(addr)] = wdata;
      else begin
        v = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 8'h00;
        if (dt == NEVER) rs.push_back('{1'b1, 8'hFF, TIMEOUT});
        else             rs.push_back('{1'b1, v, (dt == 0) ? 1 : dt});
      end
    end
    foreach (rs[i]) begin
      if (id) m1_q.push_back(rs[i]);
      else    m0_q.push_back(rs[i]);
    end
  endtask

  task automatic wait_ack(input bit id);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((id ? io.m1_ack : io.m0_ack) !== 1'b1) && n < 200);
    if (n >= 200) check($sformatf("m%0d_ack_wait", id), 0, 1);
    if (id) io.m1_io_req = 1'b0;
    else    io.m0_io_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((m0_q.size() + m1_q.size() + bus_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("drain_timeout", 0, 1);
      m0_q.delete(); m1_q.delete(); bus_q.delete(); slave_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input bit w0, input bit w1,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input int ak0, input int dt0, input int ak1, input int dt1,
                               input bit wait_done);
    bit order[$];
    if (r0 && r1) order = model_last ? '{1'b0, 1'b1} : '{1'b1, 1'b0};
    else if (r0)  order = '{1'b0};
    else          order = '{1'b1};
    foreach (order[i]) begin
      if (order[i]) model_txn(1'b1, w1, a1, d1, ak1, dt1);
      else          model_txn(1'b0, w0, a0, d0, ak0, dt0);
      model_last = order[i];
    end
    @(negedge clk);
    io.m0_io_req = r0; io.m0_wrt = w0; io.m0_address = a0; io.m0_wdata = d0;
    io.m1_io_req = r1; io.m1_wrt = w1; io.m1_address = a1; io.m1_wdata = d1;
    fork
      begin if (r0) wait_ack(1'b0); end
      begin if (r1) wait_ack(1'b1); end
    join
    if (wait_done) wait_drain();
  endtask

  task automatic checkOutput();
    check("rst_pulses", {io.m0_ack, io.m1_ack, io.m0_rdata_en, io.m1_rdata_en}, 0);
    check("rst_bus_ctl", {io.bus_io_req, io.bus_wrt, io.grant_id}, 0);
    check("rst_bus_address", io.bus_address, 16'h0000);
    check("rst_bus_wdata", io.bus_wdata, 8'h00);
    check("rst_rdata", {io.m0_rdata, io.m1_rdata}, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    io.m0_io_req = 1'b0;
    io.m1_io_req = 1'b0;
    #1;
    checkOutput();
    m0_q.delete(); m1_q.delete(); bus_q.delete(); slave_q.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running, required finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    io.m0_io_req = 1'b0; io.m0_wrt = 1'b0; io.m0_address = 16'h0000; io.m0_wdata = 8'h00;
    io.m1_io_req = 1'b0; io.m1_wrt = 1'b0; io.m1_address = 16'h0000; io.m1_wdata = 8'h00;
    #1;
    checkOutput();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed: write, read-back, contention");
    applyStimulus(1, 0, 1, 0, 16'h00FC, 16'h0000, 8'h12, 8'h00, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h00FC, 8'h00, 8'h00, 0, 0, 2, 2, 1);
    do_reset();
    applyStimulus(1, 1, 1, 0, 16'h00FD, 16'h00FD, 8'h23, 8'h00, 0, 0, 1, 0, 1);

    $display("[TB] directed: watchdog cases");
    applyStimulus(1, 0, 0, 0, 16'h001C, 16'h0000, 8'h00, 8'h00, NEVER, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 16'h0010, 16'h0000, 8'h5A, 8'h00, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0010, 8'h00, 8'h00, 0, 0, 1, NEVER, 1);

    $display("[TB] directed: reset during read data wait");
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h00FC, 8'h00, 8'h00, 0, 0, 1, NEVER, 0);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    applyStimulus(1, 1, 0, 1, 16'h00FD, 16'h0011, 8'h00, 8'h77, 2, 3, 0, 0, 1);

    $display("[TB] random rounds");
    for (int i = 0; i < 40; i++) begin
      bit r0, r1, w0, w1;
      int ak0, dt0, ak1, dt1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      ak0 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      ak1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      dt0 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      dt1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      applyStimulus(r0, r1, w0, w1,
                    16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), ak0, dt0, ak1, dt1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
